mips_mc_core: RTL
=================

Name: mips_mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS top: one datapath, one FSM controller, one unified instruction/data memory port with a request/ready handshake.
- Tolerates variable-latency memory (wait states), supports XLEN-wide data and a configurable reset vector, and halts cleanly on illegal opcodes.
- Sits at the top of the CPU; external memory model/arbiter attaches to the mem_* port.

Parameters:
- XLEN, 32, datapath/register width; must be >= 32; instruction = mem_rdata[31:0]; immediates sign-extended to XLEN.
- ADDR_W, 32, byte-address width, <= XLEN; mem_addr = low ADDR_W bits of PC/ALU result.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (sw), 0 = read (fetch/lw).
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  access complete.
- halted  out  1  core stopped on illegal opcode.
- pc_out  out  ADDR_W  current PC (debug).

Behaviour:
- Reset (rst=0 at edge): state=FETCH, PC=RESET_PC, all 32 registers=0, IR=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0. Reset mid-access abandons the access; mem_req falls on the next cycle.
- ISA: R-type add, sub, and, or, slt (funct 20,22,24,25,2A hex), jr (funct 08); addi, slti, lw, sw, beq, j, jal. Any other opcode/funct -> HALT.
- $0 reads 0; writes to $0 are dropped.
- States: FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}; MEM -> {WB, FETCH}; HALT absorbing until reset.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready: IR<=rdata[31:0], PC<=PC+4, go DECODE.
- DECODE: read rs/rt into A/B, sign-extend imm; illegal -> HALT (halted=1 registered on entry).
- EXEC: ALU op. beq: if A==B, PC<=PC+4+(simm<<2), -> FETCH. j: PC<={PC[top:28],target,2'b00}, -> FETCH. jal: same plus $31<=PC (already +4), -> FETCH. jr: PC<=A, -> FETCH. lw/sw -> MEM. R-type/addi/slti -> WB.
- MEM: mem_req=1, mem_addr=A+simm, mem_we=1 for sw with mem_wdata=B; hold all mem_* stable until mem_ready; sw -> FETCH, lw latches rdata -> WB.
- WB: write rd (R-type), rt (addi/slti/lw).
- Handshake: mem_ready may be 1 in the first request cycle (zero wait); mem_ready while mem_req=0 is ignored; no timeout.
- Latency with zero waits: R-type/addi/slti 4 cycles, lw 5, sw 4, beq/j/jal/jr 3; each wait cycle adds 1.
- Arithmetic: XLEN-bit two's complement wrap, no overflow trap; slt/slti signed compare; PC wraps modulo 2^ADDR_W.
- pc_out tracks the PC register; halted stays 1 with mem_req=0 until reset.

Decomposition:
- Shared package mips_pkg: opcode/funct constants, FSM state enum, ALU-op encoding.
- One sub-module: mips_regfile (32 x XLEN, 2 async read, 1 sync write, sync active-low clear, $0 hardwired).
- ALU and FSM inline in mips_mc_core.

Test Plan:
- Reset: hold rst=0 for 3 cycles with RESET_PC=0x100 -> first request has mem_addr=0x100, mem_we=0; halted=0.
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1, zero-wait memory -> $3=2, $4=1; each ALU instruction takes 4 cycles.
- sw $3,8($0) then lw $5,8($0), memory inserting 2 wait cycles on every access -> write cycle shows addr=8, wdata=2, and mem_* held stable across waits; $5=2.
- beq taken (offset +2) and not taken; jal to 0x40 then jr $31 -> PC sequence correct; $31=jal address+4; $0 stays 0 after addi $0,$0,7.
- Illegal opcode 0x3F -> halted=1 after DECODE; mem_req stays 0; asserting rst=0 restarts fetch at RESET_PC.
- rst=0 asserted while a lw MEM access is waiting -> mem_req=0 the next cycle, registers cleared, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the multi-cycle MIPS core.
//   - opcode / funct encodings of the supported instruction subset
//   - FSM state enum, decoded-instruction enum, ALU operation enum
//   - decode helpers used by the controller
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [4:0] RA_REG   = 5'd31;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_JR,
    I_ADDI, I_SLTI, I_LW, I_SW, I_BEQ, I_J, I_JAL,
    I_ILLEGAL
  } instr_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  function automatic instr_e decode_instr(input logic [5:0] op, input logic [5:0] fn);
    instr_e res;
    res = I_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  res = I_ADD;
          FN_SUB:  res = I_SUB;
          FN_AND:  res = I_AND;
          FN_OR:   res = I_OR;
          FN_SLT:  res = I_SLT;
          FN_JR:   res = I_JR;
          default: res = I_ILLEGAL;
        endcase
      end
      OP_J:    res = I_J;
      OP_JAL:  res = I_JAL;
      OP_BEQ:  res = I_BEQ;
      OP_ADDI: res = I_ADDI;
      OP_SLTI: res = I_SLTI;
      OP_LW:   res = I_LW;
      OP_SW:   res = I_SW;
      default: res = I_ILLEGAL;
    endcase
    return res;
  endfunction

  // R-type ALU instructions take B from rt and write rd; the rest use the immediate and rt.
  function automatic logic is_rtype_alu(input instr_e i);
    return (i == I_ADD) || (i == I_SUB) || (i == I_AND) || (i == I_OR) || (i == I_SLT);
  endfunction

  function automatic alu_op_e alu_op_of(input instr_e i);
    alu_op_e res;
    case (i)
      I_SUB:          res = ALU_SUB;
      I_AND:          res = ALU_AND;
      I_OR:           res = ALU_OR;
      I_SLT, I_SLTI:  res = ALU_SLT;
      default:        res = ALU_ADD;  // add, addi, lw/sw address
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x XLEN register file.
//   clk, rst        clock, synchronous active-low clear of all entries
//   i_raddr_a/b     asynchronous read addresses, o_rdata_a/b read data
//   i_we, i_waddr,  synchronous write port; writes to $0 are dropped
//   i_wdata
// $0 always reads as zero.
module mips_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_raddr_a,
  input  logic [4:0]      i_raddr_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata
);

  logic [XLEN-1:0] r_regs [0:31];

  // NOTE: the array has a reset because the core must see all-zero registers after reset;
  // that makes it plain flops rather than an inferable RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS core with a unified request/ready memory port.
//   clk, rst     clock, synchronous active-low reset
//   mem_req      access request (held until mem_ready)
//   mem_we       1 = store, 0 = fetch / load
//   mem_addr     byte address, mem_wdata store data
//   mem_rdata    read data, valid when mem_ready=1
//   mem_ready    access complete
//   halted       stopped on an illegal instruction
//   pc_out       current PC
// All mem_* outputs are registered: a state that owns the bus gets its request
// set up by the transition into it, so zero-wait accesses finish in one cycle.
module mips_mc_core
  import mips_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  state_e            r_state;
  instr_e            r_instr;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [XLEN-1:0]   r_a, r_b, r_simm, r_alu, r_mdr;

  logic [XLEN-1:0]   w_rdata_a, w_rdata_b;
  logic              w_rf_we;
  logic [4:0]        w_rf_waddr;
  logic [XLEN-1:0]   w_rf_wdata;
  instr_e            w_decoded;
  logic [XLEN-1:0]   w_imm_sext;
  logic [XLEN-1:0]   w_pc_x;
  logic [XLEN-1:0]   w_alu_b;
  alu_op_e           w_alu_op;
  logic [XLEN-1:0]   w_alu_y;
  logic [ADDR_W-1:0] w_br_target, w_j_target, w_next_pc;

  mips_regfile #(.XLEN(XLEN)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_raddr_a (r_ir[25:21]),
    .i_raddr_b (r_ir[20:16]),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata)
  );

  assign w_decoded  = decode_instr(r_ir[31:26], r_ir[5:0]);
  assign w_imm_sext = {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
  assign w_pc_x     = XLEN'(r_pc);
  assign w_alu_b    = is_rtype_alu(r_instr) ? r_b : r_simm;
  assign w_alu_op   = alu_op_of(r_instr);

  // r_pc already holds the address of the following instruction in EXEC.
  assign w_br_target = r_pc + {r_simm[ADDR_W-3:0], 2'b00};
  assign w_j_target  = ADDR_W'({w_pc_x[XLEN-1:28], r_ir[25:0], 2'b00});

  always_comb begin
    w_alu_y = '0;
    case (w_alu_op)
      ALU_ADD: w_alu_y = r_a + w_alu_b;
      ALU_SUB: w_alu_y = r_a - w_alu_b;
      ALU_AND: w_alu_y = r_a & w_alu_b;
      ALU_OR:  w_alu_y = r_a | w_alu_b;
      ALU_SLT: w_alu_y = XLEN'($signed(r_a) < $signed(w_alu_b));
      default: w_alu_y = '0;
    endcase
  end

  always_comb begin
    w_next_pc = r_pc;
    case (r_instr)
      I_BEQ:      w_next_pc = (r_a == r_b) ? w_br_target : r_pc;
      I_J, I_JAL: w_next_pc = w_j_target;
      I_JR:       w_next_pc = r_a[ADDR_W-1:0];
      default:    w_next_pc = r_pc;
    endcase
  end

  // jal links in EXEC; everything else writes back in WB.
  // NOTE: every output gets a default before the branches, so no path infers a latch.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = '0;
    w_rf_wdata = '0;
    if (r_state == S_EXEC && r_instr == I_JAL) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = RA_REG;
      w_rf_wdata = w_pc_x;
    end else if (r_state == S_WB) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = is_rtype_alu(r_instr) ? r_ir[15:11] : r_ir[20:16];
      w_rf_wdata = (r_instr == I_LW) ? r_mdr : r_alu;
    end
  end

  // NOTE: sequential state is assigned with <= so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_instr   <= I_ILLEGAL;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_simm    <= '0;
      r_alu     <= '0;
      r_mdr     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!mem_req) begin
            // Only after reset: the request was not set up by a previous state.
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= r_pc;
          end else if (mem_ready) begin
            r_ir    <= mem_rdata[31:0];
            r_pc    <= r_pc + ADDR_W'(4);
            mem_req <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= w_rdata_a;
          r_b     <= w_rdata_b;
          r_simm  <= w_imm_sext;
          r_instr <= w_decoded;
          if (w_decoded == I_ILLEGAL) begin
            halted  <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_alu <= w_alu_y;
          case (r_instr)
            I_BEQ, I_J, I_JAL, I_JR: begin
              r_pc     <= w_next_pc;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= w_next_pc;
              r_state  <= S_FETCH;
            end
            I_LW, I_SW: begin
              mem_req   <= 1'b1;
              mem_we    <= (r_instr == I_SW);
              mem_addr  <= w_alu_y[ADDR_W-1:0];
              mem_wdata <= r_b;
              r_state   <= S_MEM;
            end
            default: r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (mem_we) begin
              // Store done: the bus goes straight to the next fetch.
              mem_we   <= 1'b0;
              mem_addr <= r_pc;
              r_state  <= S_FETCH;
            end else begin
              r_mdr   <= mem_rdata;
              mem_req <= 1'b0;
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= r_pc;
          r_state  <= S_FETCH;
        end
        S_HALT: begin
          mem_req <= 1'b0;
        end
        default: begin
          halted  <= 1'b1;
          mem_req <= 1'b0;
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign pc_out = r_pc;

endmodule
